// File: rtl/bch_sigma_arbiter.sv
// bch_sigma_arbiter
// Round-robin front end that lets N_CH syndrome lanes share one serial BMA
// solver. One job is in flight at a time; results come back tagged with the
// lane that produced the syndromes. A busy watchdog turns a hung solve into
// an abort result so the lanes never deadlock.
//
// P packs the BCH code parameters as {m[31:16], t[15:0]}. The syndrome bus
// carries 2t symbols of m bits, sigma carries t+1 coefficients of m bits and
// the error count must hold values 0..t.
module bch_sigma_arbiter #(
    parameter logic [31:0] P       = 32'h0005_0003,
    parameter int          N_CH    = 4,
    parameter int          TIMEOUT = 1024,
    localparam int BCH_M = int'(P[31:16]),
    localparam int BCH_T = int'(P[15:0]),
    localparam int SYN_W = 2 * BCH_T * BCH_M,
    localparam int SIG_W = (BCH_T + 1) * BCH_M,
    localparam int ERR_W = (BCH_T > 0) ? $clog2(BCH_T + 1) : 1,
    localparam int CH_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*SYN_W-1:0]  req_syndromes,
    output logic [N_CH-1:0]        grant,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic [SIG_W-1:0]       out_sigma,
    output logic [ERR_W-1:0]       out_err_count,
    output logic                   out_timeout,
    input  logic                   out_ack,
    output logic                   bma_start,
    output logic [SYN_W-1:0]       bma_syndromes,
    input  logic                   bma_ready,
    input  logic                   bma_done,
    input  logic [SIG_W-1:0]       bma_sigma,
    input  logic [ERR_W-1:0]       bma_err_count,
    output logic                   bma_ack_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    // Watchdog only needs to count up to TIMEOUT-1.
    localparam int                WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [CH_W:0]     N_CH_V  = (CH_W + 1)'(N_CH);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);
    localparam logic [N_CH-1:0]   ONE_HOT = N_CH'(1);

    state_t            state_reg;
    logic [CH_W-1:0]   rr_ptr_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [WD_W-1:0]   watchdog_reg;

    // Per-lane view of the packed syndrome bus.
    logic [SYN_W-1:0]  lane_syn [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_lane
            assign lane_syn[gi] = req_syndromes[gi*SYN_W +: SYN_W];
        end
    endgenerate

    // Rotate the request vector so bit 0 is the lane at rr_ptr; the lowest
    // set bit of the rotated vector is then the round-robin winner.
    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;

    assign req_dbl = {req, req} >> rr_ptr_reg;
    assign req_rot = req_dbl[N_CH-1:0];

    logic              pick_valid;
    logic [CH_W-1:0]   pick_off;
    logic [CH_W:0]     pick_sum;
    logic [CH_W-1:0]   pick_idx;
    logic [CH_W-1:0]   pick_next;

    // Find the winning lane and the pointer value that follows it.
    always_comb begin
        pick_valid = 1'b0;
        pick_off   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_valid = 1'b1;
                pick_off   = CH_W'(j);
            end
        end
        pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
        if (pick_sum >= N_CH_V) begin
            pick_sum = pick_sum - N_CH_V;
        end
        pick_idx  = pick_sum[CH_W-1:0];
        pick_next = (pick_idx == LAST_CH) ? '0 : pick_idx + 1'b1;
    end

    // Job sequencer: grant/start, wait for done or watchdog, hold result
    // until the consumer accepts it, and drain stale BMA results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            ch_reg        <= '0;
            watchdog_reg  <= '0;
            grant         <= '0;
            bma_start     <= 1'b0;
            bma_syndromes <= '0;
            bma_ack_done  <= 1'b0;
            out_valid     <= 1'b0;
            out_ch        <= '0;
            out_sigma     <= '0;
            out_err_count <= '0;
            out_timeout   <= 1'b0;
        end else begin
            grant        <= '0;
            bma_start    <= 1'b0;
            bma_ack_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // While our own ack_done pulse is out, the BMA may still
                    // show done for the result just accepted; that is not stale.
                    if (bma_done && !bma_ack_done) begin
                        bma_ack_done <= 1'b1;
                        state_reg    <= ST_DRAIN;
                    end else if (bma_ready && pick_valid) begin
                        grant         <= ONE_HOT << pick_idx;
                        bma_start     <= 1'b1;
                        bma_syndromes <= lane_syn[pick_idx];
                        ch_reg        <= pick_idx;
                        rr_ptr_reg    <= pick_next;
                        watchdog_reg  <= '0;
                        state_reg     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    watchdog_reg <= watchdog_reg + 1'b1;
                    if (bma_done) begin
                        out_sigma     <= bma_sigma;
                        out_err_count <= bma_err_count;
                        out_ch        <= ch_reg;
                        out_timeout   <= 1'b0;
                        out_valid     <= 1'b1;
                        state_reg     <= ST_HOLD;
                    end else if ((TIMEOUT != 0) && (watchdog_reg == WD_LAST)) begin
                        out_sigma     <= '0;
                        out_err_count <= '0;
                        out_ch        <= ch_reg;
                        out_timeout   <= 1'b1;
                        out_valid     <= 1'b1;
                        state_reg     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // An aborted solve has no BMA result to acknowledge.
                    if (out_ack) begin
                        out_valid    <= 1'b0;
                        bma_ack_done <= !out_timeout;
                        state_reg    <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
